// File: rtl/stream_demux_pkg.sv
// Shared types and helpers for the 1-to-N stream demultiplexer.
package stream_demux_pkg;

  // Packet-lock FSM states; also the type of the debug state output.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } fsm_e;

  localparam int CNT_W_DEFAULT = 16;

  // Select width for n channels, never narrower than one bit.
  function automatic int sel_w(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/stream_demux_1ton_slot.sv
// One-entry output register for a single demux channel.
// The parent only asserts fill when the slot is empty or draining this cycle,
// so a fill always wins and keeps valid high.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fill,
  input  logic [DATA_W-1:0] din,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  // Fill/drain register; data is left stale when the slot drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (fill) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux_1ton.sv
// Routes one valid/ready stream to N_CH registered output channels by in_sel.
// Out-of-range selects are accepted, discarded and counted in drop_cnt.
// Optional packet lock: define STREAM_DEMUX_PKT_LOCK_EN to hold the
// destination of the first beat of a packet until the beat with in_last=1.
//
// Handshake: a beat transfers on a clock edge where valid && ready. ready
// never depends on valid; a producer that raised valid holds its payload
// stable until the transfer. Each output slot transfers on
// out_valid[i] && out_ready[i].
module stream_demux_1ton
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = sel_w(N_CH),
  parameter int CNT_W  = CNT_W_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_last,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]       drop_cnt,
  output logic                   err_bad_sel,
  output fsm_e                   dbg_state
);

  logic [SEL_W-1:0] dest;
  logic             bad_sel;
  logic             chan_ready;
  logic             accept;
  logic [N_CH-1:0]  fill;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  fsm_e             state_q, state_d;
  logic [SEL_W-1:0] lock_q, lock_d;

  // Lock state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

  // Lock next state: first beat of a packet captures the select.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          lock_d = in_sel;
          if (!in_last) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign dest      = (state_q == LOCKED) ? lock_q : in_sel;
  assign dbg_state = state_q;
`else
  logic unused_last;

  assign dest        = in_sel;
  assign dbg_state   = IDLE;
  assign unused_last = in_last;
`endif

  assign bad_sel = (32'(dest) >= N_CH);

  // Readiness of the addressed channel slot.
  always_comb begin
    chan_ready = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      if (dest == SEL_W'(i)) chan_ready = !out_valid[i] || out_ready[i];
    end
  end

  assign in_ready = !rst && (bad_sel || chan_ready);
  assign accept   = in_valid && in_ready;

  // One-hot fill strobe towards the addressed slot.
  always_comb begin
    fill = '0;
    for (int i = 0; i < N_CH; i++) begin
      fill[i] = accept && !bad_sel && (dest == SEL_W'(i));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_slot
    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .fill  (fill[g]),
      .din   (in_data),
      .ready (out_ready[g]),
      .valid (out_valid[g]),
      .data  (out_data[g*DATA_W +: DATA_W])
    );
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_bad_sel <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      err_bad_sel <= accept && bad_sel;
      if (accept && bad_sel && (drop_cnt != {CNT_W{1'b1}})) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Bench for stream_demux_1ton: a 4-channel instance carries directed and
// random traffic against per-channel expected queues; a 3-channel instance
// with a 2-bit counter covers out-of-range selects and counter saturation.
module tb_stream_demux_1ton;
  import stream_demux_pkg::*;

  localparam int DW  = 8;
  localparam int NCH = 4;
  localparam int SW  = 2;
  localparam int CW  = 16;
  localparam int NB  = 3;
  localparam int CWB = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance
  logic              in_valid, in_ready, in_last;
  logic [DW-1:0]     in_data;
  logic [SW-1:0]     in_sel;
  logic [NCH-1:0]    out_valid, out_ready;
  logic [NCH*DW-1:0] out_data;
  logic [CW-1:0]     drop_cnt;
  logic              err_bad_sel;
  fsm_e              dbg_state;

  // 3-channel instance
  logic             b_in_valid, b_in_ready, b_in_last;
  logic [DW-1:0]    b_in_data;
  logic [SW-1:0]    b_in_sel;
  logic [NB-1:0]    b_out_valid, b_out_ready;
  logic [NB*DW-1:0] b_out_data;
  logic [CWB-1:0]   b_drop_cnt;
  logic             b_err;
  fsm_e             b_state;

  stream_demux_1ton #(.DATA_W(DW), .N_CH(NCH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt), .err_bad_sel(err_bad_sel), .dbg_state(dbg_state)
  );

  stream_demux_1ton #(.DATA_W(DW), .N_CH(NB), .CNT_W(CWB)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .drop_cnt(b_drop_cnt), .err_bad_sel(b_err), .dbg_state(b_state)
  );

  // scoreboard state
  logic [DW-1:0] exp_q [NCH][$];
  int checks   = 0;
  int failures = 0;
  bit done     = 0;
  bit          m_locked = 0;
  logic [SW-1:0] m_ch   = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Driver: present one beat, wait (bounded) for acceptance, record the
  // expected delivery. Returns at #1 after the accepting edge.
  task automatic send(input logic [SW-1:0] sel, input logic [DW-1:0] data,
                      input logic last, output int waited);
    logic [SW-1:0] dst;
    bit ok;
    waited   = 0;
    ok       = 0;
    in_valid = 1'b1;
    in_sel   = sel;
    in_data  = data;
    in_last  = last;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
      waited++;
      @(posedge clk); #1;
    end
    if (ok) begin
      dst = sel;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
      if (m_locked) dst = m_ch;
      if (!m_locked) begin
        m_ch     = sel;
        m_locked = !last;
      end else if (last) begin
        m_locked = 0;
      end
`endif
      exp_q[dst].push_back(data);
      @(posedge clk); #1;
    end else begin
      checks++;
      failures++;
      $display("FAIL send_timeout sel=%0d actual=not_accepted required=accepted", sel);
    end
    in_valid = 1'b0;
  endtask

  // Monitor: every output transfer must match the head of its channel queue.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL mon_unexpected ch=%0d actual=%0h required=none", i, out_data[i*DW +: DW]);
          end else begin
            check($sformatf("mon_ch%0d", i), 32'(out_data[i*DW +: DW]), 32'(exp_q[i].pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  w, tw;
    time t0;
    rst = 1'b1;
    in_valid = 0; in_sel = '0; in_data = '0; in_last = 1'b1; out_ready = '1;
    b_in_valid = 0; b_in_sel = '0; b_in_data = '0; b_in_last = 1'b1; b_out_ready = '1;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    check("rst_err", 32'(err_bad_sel), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_b_in_ready", 32'(b_in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // basic routing, one cycle latency
    for (int s = 0; s < NCH; s++) begin
      send(2'(s), 8'hA5, 1'b1, w);
      check("route_valid", 32'(out_valid), 32'(1 << s));
      check("route_data", 32'(out_data[s*DW +: DW]), 32'h A5);
    end
    @(posedge clk); #1;

    // backpressure on channel 2, channel 1 unaffected
    out_ready[2] = 1'b0;
    send(2'd2, 8'h11, 1'b1, w);
    check("bp_first_wait", w, 0);
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h22; in_last = 1'b1;
    @(negedge clk);
    check("bp_stall_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    send(2'd1, 8'h33, 1'b1, w);
    check("bp_other_ch_wait", w, 0);
    fork
      send(2'd2, 8'h22, 1'b1, w);
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready[2] = 1'b1;
      end
    join
    check("bp_stall_cycles", w, 3);
    repeat (3) @(posedge clk);
    #1;
    check("bp_drained", exp_q[2].size(), 0);

    // full throughput on channel 0
    out_ready = '1;
    tw = 0;
    t0 = $time;
    for (int i = 0; i < 8; i++) begin
      send(2'd0, 8'(8'h40 + i), 1'b1, w);
      tw += w;
    end
    check("tput_stalls", tw, 0);
    check("tput_cycles", 32'(($time - t0) / 10), 8);
    @(posedge clk); #1;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    // packet lock: a 3-beat packet follows its first select
    send(2'd1, 8'hB1, 1'b0, w);
    check("lock_b1", 32'(out_valid), 32'b0010);
    send(2'd3, 8'hB2, 1'b0, w);
    check("lock_b2", 32'(out_valid), 32'b0010);
    send(2'd0, 8'hB3, 1'b1, w);
    check("lock_b3", 32'(out_valid), 32'b0010);
    check("lock_b3_data", 32'(out_data[1*DW +: DW]), 32'h B3);
    send(2'd2, 8'hB4, 1'b1, w);
    check("lock_next_pkt", 32'(out_valid), 32'b0100);
    @(posedge clk); #1;
`endif

    // out-of-range select on the 3-channel instance
    for (int k = 0; k < 2; k++) begin
      b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'($urandom);
      @(negedge clk);
      check("bad_ready", 32'(b_in_ready), 1);
      @(posedge clk); #1;
      check("bad_err_pulse", 32'(b_err), 1);
      check("bad_no_valid", 32'(b_out_valid), 0);
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("bad_err_clear", 32'(b_err), 0);
    check("bad_drop_2", 32'(b_drop_cnt), 2);
    for (int k = 0; k < 3; k++) begin
      b_in_valid = 1'b1; b_in_sel = 2'd3;
      @(posedge clk); #1;
    end
    b_in_valid = 1'b0;
    @(posedge clk); #1;
    check("bad_drop_sat", 32'(b_drop_cnt), 3);
    b_in_valid = 1'b1; b_in_sel = 2'd2; b_in_data = 8'h77;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    check("b_route_valid", 32'(b_out_valid), 32'b100);
    check("b_route_data", 32'(b_out_data[2*DW +: DW]), 32'h 77);

    // randomized traffic with random consumer backpressure
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send(2'($urandom_range(0, 3)), 8'($urandom),
               (n == 299) ? 1'b1 : 1'($urandom_range(0, 2) == 0), w);
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 4'($urandom);
        end
      end
    join
    out_ready = '1;
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) check($sformatf("rand_drain_ch%0d", i), exp_q[i].size(), 0);

    // reset mid-stream discards buffered beats
    out_ready = '0;
    send(2'd0, 8'hD0, 1'b1, w);
    send(2'd3, 8'hD3, 1'b1, w);
    check("mid_fill", 32'(out_valid), 32'b1001);
    rst = 1'b1;
    for (int i = 0; i < NCH; i++) exp_q[i].delete();
    m_locked = 0;
    in_valid = 1'b1; in_sel = 2'd2; in_data = 8'hEE;
    @(negedge clk);
    check("mid_rst_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("mid_out_valid", 32'(out_valid), 0);
    check("mid_drop_cnt", 32'(b_drop_cnt), 0);
    check("mid_state", 32'(dbg_state), 32'(IDLE));
    out_ready = '1;
    send(2'd2, 8'h5C, 1'b1, w);
    check("mid_after_valid", 32'(out_valid), 32'b0100);
    check("mid_after_data", 32'(out_data[2*DW +: DW]), 32'h 5C);
    repeat (3) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_demux_1ton.md
Name: stream_demux_1toN

Overview:
- Parametrised successor to the combinational 1-to-4 demux.
- Routes a valid/ready data stream to one of N_CH output channels selected by in_sel.
- Each channel has a one-entry registered output slot; outputs are flop-driven and apply backpressure independently.
- Sits between a single producer and N consumers in the datapath fabric.

Parameters:
- DATA_W, 8, payload width in bits.
- N_CH, 4, number of output channels (2..16).
- SEL_W, $clog2(N_CH) (minimum 1), select width.
- CNT_W, 16, width of the dropped-beat counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted this cycle when in_valid && in_ready.
- in_data  in  DATA_W  input payload.
- in_sel  in  SEL_W  destination channel index.
- in_last  in  1  last beat of packet (used only with packet lock).
- out_valid  out  N_CH  per-channel slot full.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH*DATA_W  flattened payloads; channel i occupies bits [i*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  saturating count of dropped beats.
- err_bad_sel  out  1  one-cycle pulse per dropped beat.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - out_valid=0, out_data=0, drop_cnt=0, err_bad_sel=0, FSM=IDLE.
  - in_ready=0 while rst is high.
- Effective destination d:
  - Without lock: d = in_sel.
  - With lock: d = locked channel (see Optional Feature).
- Valid d (d < N_CH):
  - in_ready = !out_valid[d] || out_ready[d].
  - Combinational from out_valid, out_ready and in_sel only; never from in_valid.
- Out-of-range d (d >= N_CH):
  - in_ready = 1 and the beat is discarded.
  - err_bad_sel pulses high for the cycle after acceptance.
  - drop_cnt increments by 1 and saturates at all-ones, with no wrap.
- Latency: a beat accepted at edge k appears with out_valid[d]=1 and out_data[d] loaded after edge k. That is one cycle of latency.
- Channel slot i, evaluated each edge:
  - Fill and drain in the same cycle: the slot reloads with the new beat and out_valid stays 1. This gives full throughput with no bubble.
  - Drain only (out_valid[i] && out_ready[i], no fill): out_valid[i] goes to 0. out_data[i] holds its stale value.
  - Fill only: out_valid[i] goes to 1.
- Channels are independent: a stalled channel never blocks beats destined for other channels.
- Ordering is preserved per channel. There is no ordering guarantee across channels.
- in_data/in_sel may change arbitrarily while in_valid=0. While in_valid=1 and in_ready=0, the producer holds them stable.
- Reset mid-operation: all buffered beats are discarded, with no flush to outputs.

Optional Feature:
- Macro: STREAM_DEMUX_PKT_LOCK_EN.
- Defined (packet mode):
  - FSM states are IDLE and LOCKED.
  - In IDLE, the first accepted beat samples in_sel into lock_ch. If in_last=0, the FSM moves to LOCKED.
  - In LOCKED, d = lock_ch and in_sel is ignored.
  - An accepted beat with in_last=1 returns the FSM to IDLE.
  - A single-beat packet (in_last=1 on the first beat) stays in IDLE.
  - An out-of-range first beat locks to drop: the whole packet is dropped and counted per beat.
- Undefined: no FSM, in_sel is used per beat, and in_last is ignored.

Decomposition:
- Package stream_demux_pkg:
  - typedef fsm_e {IDLE, LOCKED}.
  - function sel_w(n) returning the max of 1 and $clog2(n).
  - localparam CNT_W_DEFAULT = 16.
- Sub-module demux_out_slot:
  - One-entry register holding valid/data with fill/drain logic.
  - Instantiated N_CH times via generate.

Test Plan:
- Basic routing: N_CH=4, all out_ready=1, din=8'hA5, sweep sel 0..3 → exactly one out_valid bit set per cycle, one cycle after acceptance, with the matching out_data; other channels stay 0.
- Backpressure: out_ready[2]=0, send two beats to ch2 (8'h11, 8'h22):
  - After the first beat is accepted, in_ready=0 while the second beat targets ch2.
  - A beat to ch1 meanwhile is accepted.
  - Releasing out_ready[2] delivers 8'h11, then 8'h22.
- Full throughput: continuous 8 beats to ch0 with out_ready[0]=1 → 8 accepted in 8 consecutive cycles with no bubble.
- Bad select: N_CH=3, in_sel=3 for 2 beats → in_ready=1, no out_valid, err_bad_sel pulses twice, drop_cnt=2. CNT_W=2 with 5 drops → drop_cnt saturates at 3.
- Packet lock (macro defined): send a 3-beat packet with sel=1,3,0 and last on beat 3 → all 3 beats appear on ch1. The next packet with sel=2 goes to ch2.
- Reset mid-stream: fill ch0 and ch3 slots, assert rst for 1 cycle → out_valid=0, drop_cnt=0, FSM=IDLE, and a following beat routes per the new in_sel.
